// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the multiplier datapath
// and the dot-product accumulator.
package mult_pkg;
    localparam int OPER_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/dot_product_ctrl.sv
// Sequencing FSM and term counter for dot_product_acc.
// state | meaning
// ACC   | accepting operand pairs, counting terms
// DRAIN | last product being added, inputs blocked
// DONE  | result presented, waiting for out_ready
module dot_product_ctrl
    import mult_pkg::*;
#(
    parameter int LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid
);
    localparam int CNT_W = $clog2(LEN) + 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt == CNT_W'(LEN - 1)) state_nxt = DRAIN;
                    else                        cnt_nxt   = cnt + 1'b1;
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end
endmodule

// File: rtl/multiplier.sv
// Combinational unsigned 4x4 array multiplier: shifted partial products
// summed into an 8-bit product.
module multiplier
    import mult_pkg::*;
(
    input  logic [OPER_W-1:0] a,
    input  logic [OPER_W-1:0] b,
    output logic [PROD_W-1:0] p
);
    always_comb begin
        p = '0;
        for (int i = 0; i < OPER_W; i++) begin
            if (b[i]) p = p + (PROD_W'(a) << i);
        end
    end
endmodule

// File: rtl/dot_product_acc.sv
// Multiply-accumulate stage: sums LEN products of 4-bit pairs and hands the
// result downstream. Define DOT_PRODUCT_SATURATE_EN for clamping with overflow flag.
module dot_product_acc
    import mult_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPER_W-1:0] a,
    input  logic [OPER_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf
);
    logic [OPER_W-1:0] a_q, b_q;
    logic              op_v;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    dot_product_ctrl #(.LEN(LEN)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid)
    );

    multiplier u_mult (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_v <= 1'b0;
        end else begin
            op_v <= in_xfer;
            if (in_xfer) begin
                a_q <= a;
                b_q <= b;
            end
        end
    end

`ifdef DOT_PRODUCT_SATURATE_EN
    logic [ACC_W:0] sum;
    logic           ovf_q;

    assign sum     = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    // Sticky until the result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ovf_q <= 1'b0;
        else if (out_xfer)          ovf_q <= 1'b0;
        else if (op_v && sum[ACC_W]) ovf_q <= 1'b1;
    end
    assign out_ovf = ovf_q;
`else
    assign acc_nxt = acc + ACC_W'(prod);
    assign out_ovf = 1'b0;
`endif

    // op_v is always clear in DONE, so a consume never races an add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc <= '0;
        else if (out_xfer) acc <= '0;
        else if (op_v)     acc <= acc_nxt;
    end

    assign out_data = acc;
endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: a 10-bit and an 8-bit accumulator
// instance share one stimulus stream.
module tb_dot_product_acc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       in_ready, out_valid, out_ovf;
    logic [9:0] out_data;
    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_data8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dot_product_acc #(.LEN(4), .ACC_W(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    dot_product_acc #(.LEN(4), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_ovf(out_ovf8)
    );

`ifdef DOT_PRODUCT_SATURATE_EN
    localparam int OVF8_DATA = 255;
    localparam int OVF8_FLAG = 1;
`else
    localparam int OVF8_DATA = 132;
    localparam int OVF8_FLAG = 0;
`endif

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one pair during the next cycle; handshake lands on the following posedge.
    task automatic send(input int av, input int bv);
        @(negedge clk);
        check("in_ready_acc", int'(in_ready), 1);
        in_valid = 1'b1;
        a = 4'(av);
        b = 4'(bv);
    endtask

    task automatic gap();
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'hf;
        b = 4'hf;
    endtask

    // Wait (bounded) for out_valid; leaves the bench at the negedge it was seen.
    task automatic wait_result(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, int'(out_valid), 1);
    endtask

    task automatic consume_check();
        @(negedge clk);
        check("post_consume_valid", int'(out_valid), 0);
        check("post_consume_ready", int'(in_ready), 1);
    endtask

    int gap_v[7] = '{1, 0, 0, 1, 0, 1, 1};
    int gap_a[4] = '{3, 5, 2, 1};
    int gap_b[4] = '{4, 5, 2, 7};

    initial begin
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ovf", int'(out_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // Basic sum with latency check
        send(1, 1); send(2, 3); send(15, 15); send(0, 9);
        gap();
        check("drain_valid", int'(out_valid), 0);
        check("drain_ready", int'(in_ready), 0);
        @(negedge clk);
        check("lat_valid", int'(out_valid), 1);
        check("basic_data", int'(out_data), 232);
        check("basic_ovf", int'(out_ovf), 0);
        consume_check();

        // Maximum value, plus overflow on the 8-bit instance
        send(15, 15); send(15, 15); send(15, 15); send(15, 15);
        gap();
        wait_result("max");
        check("max_data", int'(out_data), 900);
        check("max_ovf", int'(out_ovf), 0);
        check("ovf8_valid", int'(out_valid8), 1);
        check("ovf8_data", int'(out_data8), OVF8_DATA);
        check("ovf8_flag", int'(out_ovf8), OVF8_FLAG);
        consume_check();

        // Backpressure
        out_ready = 1'b0;
        send(2, 3); send(2, 3); send(2, 3); send(2, 3);
        gap();
        wait_result("bp");
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", int'(out_data), 24);
            check("bp_ovf", int'(out_ovf), 0);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp8_ovf", int'(out_ovf8), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        consume_check();
        send(1, 1); send(1, 2); send(1, 3); send(1, 4);
        gap();
        wait_result("after_bp");
        check("after_bp_data", int'(out_data), 10);
        consume_check();

        // Input gaps: garbage on a/b while in_valid is low must be ignored
        begin
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                if (gap_v[i] == 1) begin
                    send(gap_a[k], gap_b[k]);
                    k++;
                end else begin
                    gap();
                end
            end
        end
        gap();
        wait_result("gaps");
        check("gaps_data", int'(out_data), 48);
        consume_check();

        // Reset mid-operation
        send(7, 7); send(7, 7);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_ovf", int'(out_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", int'(in_ready), 1);
        send(1, 2); send(1, 2); send(1, 2); send(1, 2);
        gap();
        wait_result("fresh");
        check("fresh_data", int'(out_data), 8);
        check("fresh8_data", int'(out_data8), 8);
        check("fresh8_ovf", int'(out_ovf8), 0);
        consume_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
